// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg -- shared constants and types for the interrupt controller.
//   INTC_NUM_SRC : number of interrupt sources (bit 0 = highest priority)
//   ADDR_*       : register map of the bus-accessible registers
//   intc_state_t : FSM state encoding (also returned by STATUS reads)
//   MASK_RST     : mask value after reset (all sources enabled)
// -----------------------------------------------------------------------------
package intc_pkg;

   localparam int INTC_NUM_SRC = 4;
   localparam int INTC_ID_W    = 2;

   localparam logic [1:0] ADDR_MASK    = 2'd0;
   localparam logic [1:0] ADDR_PENDING = 2'd1;
   localparam logic [1:0] ADDR_CAUSE   = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef logic [1:0] intc_state_t;
   localparam intc_state_t ST_IDLE    = 2'd0;
   localparam intc_state_t ST_REQ     = 2'd1;
   localparam intc_state_t ST_SERVICE = 2'd2;

   localparam logic [INTC_NUM_SRC-1:0] MASK_RST = 4'hF;

   // One-hot vector selecting source idx.
   function automatic logic [INTC_NUM_SRC-1:0] onehot(input logic [INTC_ID_W-1:0] idx);
      logic [INTC_NUM_SRC-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/int_controller_if.sv
// -----------------------------------------------------------------------------
// int_controller_if -- register access bus of the interrupt controller.
//   sel   : access strobe
//   we    : 1 = write, 0 = read (valid with sel)
//   addr  : register select (MASK/PENDING/CAUSE/STATUS)
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read strobe
// master = bus initiator, slave = int_controller.
// -----------------------------------------------------------------------------
interface int_controller_if;

   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output we, output addr, output wdata, input rdata);
   modport slave  (input sel, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/intc_prio_enc.sv
// -----------------------------------------------------------------------------
// intc_prio_enc -- combinational lowest-index priority encoder.
//   i_vec : request vector
//   o_any : at least one bit of i_vec set
//   o_idx : index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module intc_prio_enc
   import intc_pkg::*;
(
   input  logic [INTC_NUM_SRC-1:0] i_vec,
   output logic                    o_any,
   output logic [INTC_ID_W-1:0]    o_idx
);

   always_comb begin
      o_any = |i_vec;
      o_idx = '0;
      // Scan from the top down so the lowest set index is written last.
      for (int i = INTC_NUM_SRC - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = i[INTC_ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller -- 4-source prioritised interrupt controller.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   irq_src  : interrupt sources (clk-synchronous, bit 0 = highest priority)
//   int_sig  : registered interrupt request to the control unit
//   int_ack  : pulse, control unit has taken the interrupt
//   int_done : pulse, control unit executed RFE
//   int_id   : registered index of the source requested/serviced
//   bus      : register access port (int_controller_if.slave)
// Build option: define INTC_EDGE_DETECT_EN for rising-edge capture of
// irq_src; otherwise sources are level-captured every cycle.
// -----------------------------------------------------------------------------
module int_controller
   import intc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [INTC_NUM_SRC-1:0] irq_src,
   output logic                    int_sig,
   input  logic                    int_ack,
   input  logic                    int_done,
   output logic [INTC_ID_W-1:0]    int_id,
   int_controller_if.slave         bus
);

   intc_state_t             r_state;
   logic [INTC_NUM_SRC-1:0] r_pending;
   logic [INTC_NUM_SRC-1:0] r_mask;
   logic                    r_int_sig;
   logic [INTC_ID_W-1:0]    r_int_id;
   logic [31:0]             r_rdata;

   logic [INTC_NUM_SRC-1:0] w_capture;
   logic [INTC_NUM_SRC-1:0] w_w1c;
   logic [INTC_NUM_SRC-1:0] w_ack_clr;
   logic                    w_rd;
   logic                    w_wr;
   logic                    w_any;
   logic [INTC_ID_W-1:0]    w_idx;
   logic                    w_unused_wdata;

`ifdef INTC_EDGE_DETECT_EN
   logic [INTC_NUM_SRC-1:0] r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= '0;
      end else begin
         r_prev <= irq_src;
      end
   end

   assign w_capture = irq_src & ~r_prev;
`else
   assign w_capture = irq_src;
`endif

   assign w_rd = bus.sel & ~bus.we;
   assign w_wr = bus.sel &  bus.we;
   assign w_w1c     = (w_wr && bus.addr == ADDR_PENDING) ? bus.wdata[INTC_NUM_SRC-1:0] : '0;
   assign w_ack_clr = (r_state == ST_REQ && int_ack) ? onehot(r_int_id) : '0;
   assign w_unused_wdata = ^bus.wdata[31:INTC_NUM_SRC];

   intc_prio_enc u_prio_enc (
      .i_vec (r_pending & r_mask),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   // Capture is OR-ed in after the clears, so a same-cycle set beats ack/W1C.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
         r_mask    <= MASK_RST;
      end else begin
         r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_capture;
         if (w_wr && bus.addr == ADDR_MASK) begin
            r_mask <= bus.wdata[INTC_NUM_SRC-1:0];
         end
      end
   end

   // Request FSM. int_id is frozen outside IDLE, so unmasking or new
   // pending bits never retarget an outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_int_sig <= 1'b0;
         r_int_id  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state   <= ST_REQ;
                  r_int_sig <= 1'b1;
                  r_int_id  <= w_idx;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  r_state   <= ST_SERVICE;
                  r_int_sig <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (int_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_int_sig <= 1'b0;
            end
         endcase
      end
   end

   // Read data holds its last value between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_rd) begin
         case (bus.addr)
            ADDR_MASK:    r_rdata <= {28'd0, r_mask};
            ADDR_PENDING: r_rdata <= {28'd0, r_pending};
            ADDR_CAUSE:   r_rdata <= {29'd0, (r_state != ST_IDLE), r_int_id};
            default:      r_rdata <= {30'd0, r_state};
         endcase
      end
   end

   assign int_sig   = r_int_sig;
   assign int_id    = r_int_id;
   assign bus.rdata = r_rdata;

endmodule
